// File: rtl/io_bus_master_if.sv
// -----------------------------------------------------------------------------
// io_bus_master_if
//
// Bundles the CPU-side request/response handshakes and the 8-bit peripheral
// register bus driven by io_bus_master.
//
// Signals:
//   req_valid / req_ready    request handshake (CPU -> master)
//   req_write                1 = write, 0 = read
//   req_addr  [IO_ADDR_W]    starting peripheral byte address
//   req_size  [2]            00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = illegal
//   req_wdata [32]           write data, byte i goes to req_addr + i
//   resp_valid / resp_ready  response handshake (master -> CPU)
//   resp_rdata [32]          little-endian assembled read data
//   resp_err                 illegal request size
//   io_addr  [IO_ADDR_W]     peripheral address
//   io_wdata [8]             peripheral write data
//   io_rdata [8]             peripheral read data (combinational from io_addr)
//   io_read / io_write       single-cycle strobes
//   io_cs                    peripheral select
//
// Modports:
//   master  the io_bus_master side
//   slave   the CPU + peripheral side (testbench / integration)
// -----------------------------------------------------------------------------
interface io_bus_master_if #(
    parameter int unsigned IO_ADDR_W = 3
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [IO_ADDR_W-1:0] req_addr;
    logic [1:0]           req_size;
    logic [31:0]          req_wdata;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_rdata;
    logic                 resp_err;

    logic [IO_ADDR_W-1:0] io_addr;
    logic [7:0]           io_wdata;
    logic [7:0]           io_rdata;
    logic                 io_read;
    logic                 io_write;
    logic                 io_cs;

    modport master (
        input  req_valid, req_write, req_addr, req_size, req_wdata,
        input  resp_ready, io_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output io_addr, io_wdata, io_read, io_write, io_cs
    );

    modport slave (
        output req_valid, req_write, req_addr, req_size, req_wdata,
        output resp_ready, io_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  io_addr, io_wdata, io_read, io_write, io_cs
    );
endinterface

// File: rtl/io_bus_master.sv
// -----------------------------------------------------------------------------
// io_bus_master
//
// Bus initiator for the 8-bit peripheral register bus. Accepts a 1/2/4-byte
// request from the CPU load/store path, splits it into sequential single-byte
// peripheral accesses (address wrapping modulo 2**IO_ADDR_W), assembles read
// bytes little-endian and returns one response.
//
// Per byte the bus shows WAIT_STATES setup cycles (cs + address, no strobe),
// one strobe cycle, and, between bytes, one idle gap cycle with cs low.
//
// Ports:
//   clk    system clock, everything on posedge
//   rst_n  asynchronous active-low reset
//   bus    io_bus_master_if.master (request, response and peripheral bus)
//
// Parameters:
//   WAIT_STATES  setup cycles per byte before the strobe, 0..15
//   IO_ADDR_W    peripheral address width
//
// All outputs come straight from flops: the next-state logic computes the
// next value of every output alongside the next state.
// -----------------------------------------------------------------------------
module io_bus_master #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned IO_ADDR_W   = 3
) (
    input logic              clk,
    input logic              rst_n,
    io_bus_master_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_GAP,
        S_RESP
    } state_t;

    localparam bit       LP_HAS_SETUP = (WAIT_STATES != 0);
    // Last value of the setup counter; unused when there are no setup cycles.
    localparam logic [3:0] LP_WAIT_LAST = 4'(WAIT_STATES - 1);

    // Request context
    state_t               r_state,  w_state_nxt;
    logic                 r_write,  w_write_nxt;
    logic [IO_ADDR_W-1:0] r_addr,   w_addr_nxt;
    logic [31:0]          r_wdata,  w_wdata_nxt;
    logic [1:0]           r_idx,    w_idx_nxt;
    logic [1:0]           r_last,   w_last_nxt;
    logic [3:0]           r_wait,   w_wait_nxt;
    logic [31:0]          r_rdata,  w_rdata_nxt;
    logic                 r_err,    w_err_nxt;

    // Registered outputs
    logic                 r_req_ready,  w_req_ready_nxt;
    logic                 r_resp_valid, w_resp_valid_nxt;
    logic                 r_io_cs,      w_io_cs_nxt;
    logic                 r_io_read,    w_io_read_nxt;
    logic                 r_io_write,   w_io_write_nxt;
    logic [IO_ADDR_W-1:0] r_io_addr,    w_io_addr_nxt;
    logic [7:0]           r_io_wdata,   w_io_wdata_nxt;

    // Byte-start helper: IDLE and GAP both launch a byte the same way, only
    // the source of the request context differs.
    logic                 w_enter;
    logic [1:0]           w_enter_idx;
    logic [IO_ADDR_W-1:0] w_base_addr;
    logic [31:0]          w_base_wdata;
    logic                 w_base_write;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so that no path
        // through the case statement leaves one unassigned (which would infer a latch).
        w_state_nxt      = r_state;
        w_write_nxt      = r_write;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_idx_nxt        = r_idx;
        w_last_nxt       = r_last;
        w_wait_nxt       = r_wait;
        w_rdata_nxt      = r_rdata;
        w_err_nxt        = r_err;

        w_req_ready_nxt  = 1'b0;
        w_resp_valid_nxt = 1'b0;
        w_io_cs_nxt      = 1'b0;
        w_io_read_nxt    = 1'b0;
        w_io_write_nxt   = 1'b0;
        w_io_addr_nxt    = r_io_addr;   // address and data hold while cs is low
        w_io_wdata_nxt   = r_io_wdata;

        w_enter          = 1'b0;
        w_enter_idx      = r_idx;
        w_base_addr      = r_addr;
        w_base_wdata     = r_wdata;
        w_base_write     = r_write;

        unique case (r_state)
            S_IDLE: begin
                w_req_ready_nxt = 1'b1;
                // req_ready is always high in IDLE, so valid alone is the handshake.
                if (bus.req_valid) begin
                    w_req_ready_nxt = 1'b0;
                    w_write_nxt     = bus.req_write;
                    w_addr_nxt      = bus.req_addr;
                    w_wdata_nxt     = bus.req_wdata;
                    w_idx_nxt       = 2'd0;
                    w_rdata_nxt     = '0;
                    w_err_nxt       = (bus.req_size == 2'b11);
                    // Index of the last byte: 1 byte -> 0, 2 bytes -> 1, 4 bytes -> 3.
                    w_last_nxt      = (bus.req_size == 2'b10) ? 2'd3 : {1'b0, bus.req_size[0]};

                    if (bus.req_size == 2'b11) begin
                        // Illegal size: answer immediately, never touch the bus.
                        w_state_nxt      = S_RESP;
                        w_resp_valid_nxt = 1'b1;
                    end else begin
                        w_enter      = 1'b1;
                        w_enter_idx  = 2'd0;
                        w_base_addr  = bus.req_addr;
                        w_base_wdata = bus.req_wdata;
                        w_base_write = bus.req_write;
                    end
                end
            end

            S_SETUP: begin
                w_io_cs_nxt = 1'b1;
                if (r_wait == LP_WAIT_LAST) begin
                    w_state_nxt    = S_STROBE;
                    w_io_write_nxt = r_write;
                    w_io_read_nxt  = ~r_write;
                end else begin
                    w_wait_nxt = r_wait + 4'd1;
                end
            end

            S_STROBE: begin
                // io_rdata is combinational from the registered io_addr, so it is
                // valid for the whole strobe cycle.
                if (!r_write) begin
                    w_rdata_nxt[8*r_idx +: 8] = bus.io_rdata;
                end
                if (r_idx == r_last) begin
                    w_state_nxt      = S_RESP;
                    w_resp_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_GAP;
                end
            end

            S_GAP: begin
                w_idx_nxt   = r_idx + 2'd1;
                w_enter     = 1'b1;
                w_enter_idx = r_idx + 2'd1;
            end

            S_RESP: begin
                w_resp_valid_nxt = 1'b1;
                if (bus.resp_ready) begin
                    w_resp_valid_nxt = 1'b0;
                    w_req_ready_nxt  = 1'b1;
                    w_state_nxt      = S_IDLE;
                end
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_req_ready_nxt = 1'b1;
            end
        endcase

        // Launch byte w_enter_idx: cs, address and data go valid together, the
        // strobe follows immediately when there are no setup cycles.
        if (w_enter) begin
            w_wait_nxt     = 4'd0;
            w_io_cs_nxt    = 1'b1;
            w_io_addr_nxt  = w_base_addr + IO_ADDR_W'(w_enter_idx);
            w_io_wdata_nxt = w_base_wdata[8*w_enter_idx +: 8];
            if (LP_HAS_SETUP) begin
                w_state_nxt = S_SETUP;
            end else begin
                w_state_nxt    = S_STROBE;
                w_io_write_nxt = w_base_write;
                w_io_read_nxt  = ~w_base_write;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State, context and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_idx        <= 2'd0;
            r_last       <= 2'd0;
            r_wait       <= 4'd0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_io_cs      <= 1'b0;
            r_io_read    <= 1'b0;
            r_io_write   <= 1'b0;
            r_io_addr    <= '0;
            r_io_wdata   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_write      <= w_write_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_idx        <= w_idx_nxt;
            r_last       <= w_last_nxt;
            r_wait       <= w_wait_nxt;
            r_rdata      <= w_rdata_nxt;
            r_err        <= w_err_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_io_cs      <= w_io_cs_nxt;
            r_io_read    <= w_io_read_nxt;
            r_io_write   <= w_io_write_nxt;
            r_io_addr    <= w_io_addr_nxt;
            r_io_wdata   <= w_io_wdata_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.io_cs      = r_io_cs;
    assign bus.io_read    = r_io_read;
    assign bus.io_write   = r_io_write;
    assign bus.io_addr    = r_io_addr;
    assign bus.io_wdata   = r_io_wdata;

endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
- Bus initiator that drives the 8-bit peripheral register bus: 3-bit address, 8-bit write/read data, read, write and cs.
- Accepts 1/2/4-byte requests from the CPU load/store path over a valid/ready handshake.
- Splits each request into sequential single-byte peripheral accesses and assembles read bytes little-endian.
- Returns a response over a valid/ready handshake. Sits between the CPU I/O decode and the I/O peripherals (timer, UART, etc.).

Parameters:
- WAIT_STATES, 0: setup cycles per byte (cs and address valid, strobes low) before the strobe cycle. Legal range 0..15.
- IO_ADDR_W, 3: peripheral address width. Byte address wraps modulo 2**IO_ADDR_W.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at posedge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  IO_ADDR_W  starting byte address
- req_size  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = illegal
- req_wdata  in  32  write data; byte i goes to address req_addr+i
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid && resp_ready at posedge
- resp_rdata  out  32  assembled read data; unused upper bytes are 0; 0 for writes
- resp_err  out  1  illegal size
- io_addr  out  IO_ADDR_W  peripheral address
- io_wdata  out  8  peripheral write data
- io_rdata  in  8  peripheral read data (combinational from io_addr)
- io_read  out  1  read strobe
- io_write  out  1  write strobe
- io_cs  out  1  peripheral select

Behaviour:
- All outputs are registered.
- Reset values: req_ready = 1, all other outputs 0, state IDLE.
- Reset asserted mid-operation: strobes and cs drop immediately (asynchronous), the in-flight request is discarded, and no response is issued.
- States: IDLE, SETUP, STROBE, GAP, RESP.
- IDLE: req_ready = 1. On accept, latch write, addr, size, wdata; clear rdata; byte index i = 0; N = 1/2/4.
  - Legal size: go to SETUP if WAIT_STATES > 0, else STROBE.
  - Size 11: go directly to RESP with resp_err = 1. No bus cycles occur.
- req_ready is 0 in every state other than IDLE.
- SETUP:
  - io_cs = 1, io_addr = (addr + i) mod 2**IO_ADDR_W, io_wdata = wdata byte i, strobes 0.
  - Stay WAIT_STATES cycles, then go to STROBE.
- STROBE, exactly one cycle:
  - io_cs = 1, address and data as in SETUP.
  - io_write = write, io_read = !write.
  - On a read, capture io_rdata into rdata[8i+7:8i] at the end of this cycle.
  - If i == N-1, go to RESP; else go to GAP.
- GAP, one cycle: io_cs = 0, strobes 0. Then i increments and the state goes to SETUP or STROBE (same rule as IDLE).
- io_addr and io_wdata hold their last values whenever io_cs = 0.
- RESP: resp_valid = 1 with resp_rdata and resp_err stable. Hold until resp_ready; on the handshake go to IDLE, with resp_valid = 0 and req_ready = 1 in the next cycle.
- Timing, with the accept edge ending cycle 0:
  - Strobe for byte i occurs in cycle i*(WAIT_STATES+2) + WAIT_STATES + 1.
  - resp_valid first asserts in cycle N*(WAIT_STATES+2).
  - Error response asserts resp_valid in cycle 1.
- Address wrap: start 6 with 4 bytes accesses 6, 7, 0, 1. There is no error for misaligned or wrapping accesses.
- Only one request is outstanding at a time. There is no timeout; the peripheral is always ready.
- io_read and io_write are never high simultaneously, and never high without io_cs.

Test Plan:
- Write, size 10, addr 2, wdata 32'hDDCCBBAA, WAIT 0 -> write strobes in cycles 1/3/5/7 with addr/data 2/AA, 3/BB, 4/CC, 5/DD; io_cs low in cycles 2/4/6; resp_valid in cycle 8 with rdata 0 and err 0.
- Read, size 01, addr 6, model returns 8'h11 at 6 and 8'h22 at 7 -> read strobes at addr 6 then 7; resp_rdata = 32'h00002211.
- Read, size 10, addr 6 -> addresses 6, 7, 0, 1 in order; bytes assembled little-endian in that order.
- Illegal size 11 -> io_cs never asserts; resp_valid in cycle 1 with resp_err = 1 and rdata 0.
- WAIT_STATES = 2, size 00 read -> io_cs high in cycles 1-3, io_read only in cycle 3, resp in cycle 4.
- resp_ready held low 5 cycles -> resp_valid and data stable, req_ready stays 0; then a new req accepted the cycle after the handshake.
- Reset pulse during byte 2 of a 4-byte write -> io_cs and io_write go to 0 immediately; no resp_valid; req_ready = 1 after release.
